// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Boot-time feeder for the instruction RAM. Takes a byte stream from a
//   serial front end, rebuilds little-endian 32-bit words and writes them
//   one after another into the RAM starting at BASE_ADDR. The CPU core is
//   kept in reset until the whole image has landed in memory.
//
//   Image layout on the wire:
//     4 bytes  word count N, LSB first
//     4*N bytes data words, each LSB first
//     (+1 byte 8-bit modular sum of all data bytes, checksum build only)
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN - when defined, a trailing checksum byte must
//   follow the data words and match the sum of all data bytes before the
//   CPU is released; a mismatch rejects the image.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   rx_valid  in   1  byte present on rx_data this cycle (no backpressure)
//   rx_data   in   8  received byte
//   mem_we    out  1  RAM write enable, one cycle per word
//   mem_addr  out 32  RAM byte address of the current/last write
//   mem_din   out 32  RAM write data
//   cpu_hold  out  1  1 = CPU held in reset
//   done      out  1  image loaded (sticky until rst)
//   error     out  1  image rejected (sticky until rst)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int WCW = $clog2(MAX_WORDS + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]  word_cnt_q, word_cnt_d;
    logic [31:0]     len_q, len_d;
    logic [23:0]     shift_q, shift_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_din_q, mem_din_d;
    logic [31:0]     len_full;
    logic [31:0]     word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    // The incoming byte completes the length / data word in the same cycle
    // it is sampled, so the full value is formed from the buffer plus rx_data.
    assign len_full  = {rx_data, len_q[23:0]};
    assign word_full = {rx_data, shift_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LEN;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_din_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            S_LEN: begin
                if (rx_valid) begin
                    len_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_full == 32'd0) begin
                            state_d = S_AFTER_DATA;
                        end else if (len_full > MAX_WORDS) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    case (byte_cnt_q)
                        2'd0: shift_d[7:0]   = rx_data;
                        2'd1: shift_d[15:8]  = rx_data;
                        2'd2: shift_d[23:16] = rx_data;
                        default: begin
                            // Fourth byte: launch the write on this edge so the
                            // RAM sees it one cycle after the byte was sampled.
                            mem_we_d   = 1'b1;
                            mem_din_d  = word_full;
                            mem_addr_d = BASE_ADDR + (32'(word_cnt_q) << 2);
                            word_cnt_d = word_cnt_q + WCW'(1);
                            if (32'(word_cnt_q) + 32'd1 == len_q) begin
                                state_d = S_AFTER_DATA;
                            end
                        end
                    endcase
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif

            default: begin
            end
        endcase
    end

    // Completion is withheld while the final write is still on the RAM port,
    // so the CPU is only released after the last word is really stored.
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign done     = (state_q == S_DONE) && !mem_we_q;
    assign error    = (state_q == S_ERR);
    assign cpu_hold = !done;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memDin;
    logic        cpuHold;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    imem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(1024)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_valid(rxValid),
        .rx_data (rxData),
        .mem_we  (memWe),
        .mem_addr(memAddr),
        .mem_din (memDin),
        .cpu_hold(cpuHold),
        .done    (done),
        .error   (error)
    );

    // Cycle counter used to pin the write latency of every word.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural instruction RAM fed by the loader.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (memWe) ram[memAddr[11:2]] <= memDin;
    end

    // Scoreboard of expected RAM writes.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t expQ[$];

    // Table of whole-image vectors with expected final flags for both builds.
    typedef struct {
        logic [31:0] len;
        int          gap;
        logic [7:0]  csumDelta;
        logic        expDone;
        logic        expErr;
        logic        expDoneCs;
        logic        expErrCs;
    } vec_t;
    vec_t vecs[9];

    logic [31:0] imgWords [0:1023];
    logic [7:0]  curSum;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must be expected, single-cycle, on time and
    // happen while the CPU is still held.
    logic prevWe = 1'b0;
    always @(negedge clk) begin
        wr_t e;
        if (!rst && memWe) begin
            checkOutput("hold during write", cpuHold, 1);
            checkOutput("we single cycle", prevWe, 0);
            checkOutput("done/error exclusive", done & error, 0);
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected write: addr %h data %h, none expected", memAddr, memDin);
            end else begin
                e = expQ.pop_front();
                checkOutput("write addr", memAddr, e.addr);
                checkOutput("write data", memDin, e.data);
                checkOutput("write cycle", cyc, e.cyc);
            end
        end
        prevWe = memWe;
    end

    task automatic applyReset();
        rst     = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one cycle; optionally register the write it completes.
    task automatic sendByte(input logic [7:0] b, input int gap, input bit doPush,
                            input logic [31:0] addr, input logic [31:0] word);
        wr_t e;
        rxValid = 1'b1;
        rxData  = b;
        @(posedge clk);
        #1;
        if (doPush) begin
            e.addr = addr;
            e.data = word;
            e.cyc  = cyc;
            expQ.push_back(e);
        end
        rxValid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // Length, data words from imgWords, checksum byte (+delta), then junk.
    task automatic applyStimulus(input logic [31:0] len, input int gap, input logic [7:0] delta);
        logic [31:0] w;
        curSum = 8'h00;
        for (int k = 0; k < 4; k++) sendByte(len[8*k +: 8], gap, 1'b0, 32'h0, 32'h0);
        if (len != 0 && len <= 32'd1024) begin
            for (int i = 0; i < int'(len); i++) begin
                w = imgWords[i];
                for (int k = 0; k < 4; k++) begin
                    curSum = curSum + w[8*k +: 8];
                    sendByte(w[8*k +: 8], gap, k == 3, 32'(i) << 2, w);
                end
            end
        end
        sendByte(curSum + delta, gap, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) sendByte(8'hFF, gap, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic expD;
        logic expE;
        logic [31:0] l;

        //            len            gap csum  D  E  Dcs Ecs
        vecs[0] = '{32'd2,          3, 8'h00, 1, 0, 1, 0};
        vecs[1] = '{32'd2,          0, 8'h00, 1, 0, 1, 0};
        vecs[2] = '{32'd1025,       1, 8'h00, 0, 1, 0, 1};
        vecs[3] = '{32'd0,          2, 8'h00, 1, 0, 1, 0};
        vecs[4] = '{32'd0,          0, 8'h01, 1, 0, 0, 1};
        vecs[5] = '{32'd1,          0, 8'h01, 1, 0, 0, 1};
        vecs[6] = '{32'd1024,       0, 8'h00, 1, 0, 1, 0};
        vecs[7] = '{32'h0100_0000,  0, 8'h00, 0, 1, 0, 1};
        vecs[8] = '{32'd3,          1, 8'h00, 1, 0, 1, 0};

        // Reset state, sampled while reset is still asserted.
        rst     = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
        @(negedge clk);
        checkOutput("reset we", memWe, 0);
        checkOutput("reset addr", memAddr, 32'h0);
        checkOutput("reset din", memDin, 32'h0);
        checkOutput("reset hold", cpuHold, 1);
        checkOutput("reset done", done, 0);
        checkOutput("reset error", error, 0);

        for (int r = 0; r < 9; r++) begin
            applyReset();
            expQ.delete();
            for (int k = 0; k < 1024; k++) begin
                imgWords[k] = (k == 0) ? 32'h0020_81b3 :
                              (k == 1) ? 32'hDEAD_BEEF :
                              (32'hA000_0000 | (32'(k) * 32'h0001_0101) | 32'(r));
            end
            l = vecs[r].len;
            applyStimulus(l, vecs[r].gap, vecs[r].csumDelta);
`ifdef IMEM_LOADER_CHECKSUM_EN
            expD = vecs[r].expDoneCs;
            expE = vecs[r].expErrCs;
`else
            expD = vecs[r].expDone;
            expE = vecs[r].expErr;
`endif
            checkOutput($sformatf("row%0d done", r), done, expD);
            checkOutput($sformatf("row%0d error", r), error, expE);
            checkOutput($sformatf("row%0d hold", r), cpuHold, !expD);
            checkOutput($sformatf("row%0d pending writes", r), expQ.size(), 0);
            if (l != 0 && l <= 32'd1024) begin
                checkOutput($sformatf("row%0d ram last", r), ram[int'(l) - 1], imgWords[int'(l) - 1]);
                checkOutput($sformatf("row%0d addr hold", r), memAddr, (l - 32'd1) << 2);
                checkOutput($sformatf("row%0d din hold", r), memDin, imgWords[int'(l) - 1]);
            end
        end

        // Reset in the middle of an L=3 image, then a clean L=1 image.
        applyReset();
        expQ.delete();
        for (int k = 0; k < 4; k++) sendByte((k == 0) ? 8'h03 : 8'h00, 0, 1'b0, 32'h0, 32'h0);
        sendByte(8'h11, 0, 1'b0, 32'h0, 32'h0);
        sendByte(8'h22, 0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset we", memWe, 0);
        checkOutput("midreset hold", cpuHold, 1);
        checkOutput("midreset addr", memAddr, 32'h0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        imgWords[0] = 32'h0000_0013;
        applyStimulus(32'd1, 0, 8'h00);
        checkOutput("midreset done", done, 1);
        checkOutput("midreset error", error, 0);
        checkOutput("midreset ram0", ram[0], 32'h0000_0013);
        checkOutput("midreset pending", expQ.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // L=1, word 04030201: correct checksum 0A passes, 0B is rejected.
        applyReset();
        expQ.delete();
        imgWords[0] = 32'h0403_0201;
        applyStimulus(32'd1, 0, 8'h00);
        checkOutput("csum 0A sum", curSum, 8'h0A);
        checkOutput("csum 0A done", done, 1);
        checkOutput("csum 0A error", error, 0);
        applyReset();
        expQ.delete();
        applyStimulus(32'd1, 0, 8'h01);
        checkOutput("csum 0B error", error, 1);
        checkOutput("csum 0B hold", cpuHold, 1);
        checkOutput("csum 0B done", done, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream feeder of the instruction RAM (ports clk/we/addr/din).
- Receives a byte stream from a serial front end (e.g. UART RX), assembles little-endian 32-bit words and writes them sequentially into the RAM.
- Holds the CPU core in reset until the whole image is loaded.
- Image format: 4-byte little-endian word count N, then N words (4 bytes each, LSB first).

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned.
- MAX_WORDS, 1024, largest accepted N (the RAM decodes addr[11:2]).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  a byte is presented on rx_data this cycle (single-cycle pulse, no backpressure).
- rx_data  in  8  received byte.
- mem_we  out  1  RAM write enable, one cycle per word.
- mem_addr  out  32  RAM byte address.
- mem_din  out  32  RAM write data.
- cpu_hold  out  1  1 = CPU held in reset.
- done  out  1  image loaded successfully (sticky until rst).
- error  out  1  image rejected (sticky until rst).

Behaviour:
- Reset (async, immediate):
  - state=LEN, byte_cnt=0, word_cnt=0, len=0, shift=0.
  - mem_we=0, mem_addr=BASE_ADDR, mem_din=0.
  - cpu_hold=1, done=0, error=0.
- State LEN:
  - Each rx_valid shifts rx_data into len[8*byte_cnt +: 8]; byte_cnt increments.
  - On the 4th byte the complete length L is checked:
    - L==0: go to DONE.
    - L>MAX_WORDS: go to ERR.
    - Otherwise: go to DATA with byte_cnt=0.
- State DATA:
  - Each rx_valid places rx_data at byte position byte_cnt of the word buffer.
  - On the 4th byte, in the same cycle edge: mem_din = assembled word, mem_we=1 for exactly the next cycle, mem_addr = BASE_ADDR + 4*word_cnt.
  - word_cnt increments after the write. byte_cnt wraps 3→0.
- Write completion:
  - After the write with word_cnt reaching L, go to DONE.
  - The registered outputs are visible to the RAM on the following edge.
  - Write latency is 1 cycle from the edge that sampled the last byte.
- DONE:
  - done=1, cpu_hold=0.
  - Further rx_valid bytes are ignored; mem_we stays 0.
- ERR:
  - error=1, cpu_hold stays 1.
  - rx_valid is ignored until rst.
- Timing and addressing:
  - Back-to-back rx_valid (every cycle) must be accepted without loss. A byte arriving in the same cycle mem_we is high is accepted normally.
  - mem_addr holds the last written address between writes. Addresses increment by 4, never wrap: L≤MAX_WORDS bounds them.
- Outside writes: mem_din holds its last value; mem_we=0.
- Reset mid-image: all progress is discarded. A partially written RAM is not cleared; the next image overwrites from BASE_ADDR.
- done and error are never both 1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data word, one extra state CSUM waits for one byte.
  - This byte must equal the 8-bit modular sum of all 4*L data bytes (length bytes excluded).
  - Match → DONE; mismatch → ERR.
  - For L==0 the checksum byte is still required and must be 8'h00.
  - cpu_hold stays 1 until the checksum passes.
- When undefined:
  - No CSUM state and no sum register.
  - Last data word → DONE directly.

Test Plan:
- Load L=2 with words 32'h002081b3 and 32'hDEADBEEF, gaps of 3 idle cycles between bytes → two single-cycle mem_we pulses at addr 0x0 then 0x4. Data matches; done=1, cpu_hold falls after the second write. A RAM read at 0x4 returns DEADBEEF.
- Same image with rx_valid high every cycle → identical writes, no lost bytes, done after 12 accepted bytes.
- Length bytes encoding L=1025 (01 04 00 00) → error=1, cpu_hold=1, no mem_we ever. Bytes after that are ignored.
- L=0 → done=1 after the 4th byte, no writes (checksum build: needs a 00 byte first; byte 01 instead → error=1).
- Assert rst after 6 bytes of an L=3 image, then send a full L=1 image 32'h00000013 → exactly one write of 00000013 at 0x0, done=1. mem_we is 0 during reset.
- Checksum build: image L=1, word 32'h04030201, checksum 8'h0A → done=1. Checksum 8'h0B → error=1, cpu_hold=1.
